// File: rtl/nonce_sweep_ctrl_pkg.sv
// Shared types and sizes for the nonce sweep controller.
// Widths follow the mining header / SHA-256 digest layout.
package nonce_sweep_ctrl_pkg;

  localparam int HDR_W   = 608;
  localparam int NONCE_W = 32;
  localparam int DIG_W   = 256;
  localparam int MSG_W   = HDR_W + NONCE_W;
  localparam int TIMEOUT = 1024;
  localparam int WCNT_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    FIN
  } ctrl_state_t;

  typedef logic [HDR_W-1:0]   hdr_t;
  typedef logic [NONCE_W-1:0] nonce_t;
  typedef logic [DIG_W-1:0]   digest_t;
  typedef logic [MSG_W-1:0]   msg_t;
  typedef logic [NONCE_W:0]   count_t;
  typedef logic [WCNT_W-1:0]  wcnt_t;

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Request/response channel between the sweep controller and the SHA core.
// master = controller side, slave = SHA core side.
interface nonce_sweep_ctrl_if;
  import nonce_sweep_ctrl_pkg::*;

  logic    sha_start;
  msg_t    sha_msg;
  logic    sha_done;
  digest_t sha_digest;

  modport master (
    output sha_start,
    output sha_msg,
    input  sha_done,
    input  sha_digest
  );

  modport slave (
    input  sha_start,
    input  sha_msg,
    output sha_done,
    output sha_digest
  );

endinterface

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a nonce range through the SHA core, one hash at a time,
// and reports the first digest below target, exhaustion or timeout.
module nonce_sweep_ctrl
  import nonce_sweep_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   start_i,
  input  logic   abort_i,
  input  hdr_t   hdr_i,
  input  digest_t target_i,
  input  nonce_t nonce_first_i,
  input  nonce_t nonce_last_i,
  nonce_sweep_ctrl_if.master sha,
  output logic   busy_o,
  output logic   done_o,
  output logic   found_o,
  output nonce_t found_nonce_o,
  output logic   timeout_err_o,
  output count_t hash_count_o
);

  localparam wcnt_t WAIT_LIM = wcnt_t'(TIMEOUT);

  ctrl_state_t state_q, state_d;
  hdr_t    hdr_q, hdr_d;
  digest_t target_q, target_d;
  digest_t digest_q, digest_d;
  nonce_t  last_q, last_d;
  nonce_t  nonce_q, nonce_d;
  nonce_t  fnonce_q, fnonce_d;
  wcnt_t   wait_q, wait_d;
  count_t  hcnt_q, hcnt_d;
  logic    found_q, found_d;
  logic    terr_q, terr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      hdr_q    <= '0;
      target_q <= '0;
      digest_q <= '0;
      last_q   <= '0;
      nonce_q  <= '0;
      fnonce_q <= '0;
      wait_q   <= '0;
      hcnt_q   <= '0;
      found_q  <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      target_q <= target_d;
      digest_q <= digest_d;
      last_q   <= last_d;
      nonce_q  <= nonce_d;
      fnonce_q <= fnonce_d;
      wait_q   <= wait_d;
      hcnt_q   <= hcnt_d;
      found_q  <= found_d;
      terr_q   <= terr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_d    = hdr_q;
    target_d = target_q;
    digest_d = digest_q;
    last_d   = last_q;
    nonce_d  = nonce_q;
    fnonce_d = fnonce_q;
    wait_d   = wait_q;
    hcnt_d   = hcnt_q;
    found_d  = found_q;
    terr_d   = terr_q;
    // abort overrides every transition and leaves results untouched
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            hdr_d    = hdr_i;
            target_d = target_i;
            last_d   = nonce_last_i;
            nonce_d  = nonce_first_i;
            fnonce_d = '0;
            found_d  = 1'b0;
            terr_d   = 1'b0;
            hcnt_d   = '0;
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          wait_d  = '0;
          state_d = WAIT;
        end
        WAIT: begin
          if (sha.sha_done) begin
            digest_d = sha.sha_digest;
            hcnt_d   = hcnt_q + count_t'(1);
            state_d  = CHECK;
          end else if (wait_q == WAIT_LIM) begin
            terr_d  = 1'b1;
            state_d = FIN;
          end else begin
            wait_d = wait_q + wcnt_t'(1);
          end
        end
        CHECK: begin
          if (digest_q < target_q) begin
            found_d  = 1'b1;
            fnonce_d = nonce_q;
            state_d  = FIN;
          end else if (nonce_q == last_q) begin
            state_d = FIN;
          end else begin
            nonce_d = nonce_q + nonce_t'(1);
            state_d = ISSUE;
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // outputs read as reset values during the rst cycle itself
  assign sha.sha_start = ~rst & (state_q == ISSUE);
  assign sha.sha_msg   = rst ? '0 : {hdr_q, nonce_q};
  assign busy_o        = ~rst & (state_q != IDLE);
  assign done_o        = ~rst & (state_q == FIN);
  assign found_o       = ~rst & found_q;
  assign timeout_err_o = ~rst & terr_q;
  assign found_nonce_o = rst ? '0 : fnonce_q;
  assign hash_count_o  = rst ? '0 : hcnt_q;

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Scoreboard bench for nonce_sweep_ctrl with a fixed-latency SHA model.
// Digest model: {nonce, 224 ones}, 64 cycles after sha_start.
module tb_nonce_sweep_ctrl;
  import nonce_sweep_ctrl_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    start_i = 1'b0;
  logic    abort_i = 1'b0;
  hdr_t    hdr_i = '0;
  digest_t target_i = '0;
  nonce_t  nonce_first_i = '0;
  nonce_t  nonce_last_i = '0;
  logic    busy_o, done_o, found_o, timeout_err_o;
  nonce_t  found_nonce_o;
  count_t  hash_count_o;

  nonce_sweep_ctrl_if sha_if ();

  nonce_sweep_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .abort_i       (abort_i),
    .hdr_i         (hdr_i),
    .target_i      (target_i),
    .nonce_first_i (nonce_first_i),
    .nonce_last_i  (nonce_last_i),
    .sha           (sha_if.master),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .found_o       (found_o),
    .found_nonce_o (found_nonce_o),
    .timeout_err_o (timeout_err_o),
    .hash_count_o  (hash_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic   found;
    nonce_t fn;
    logic   terr;
    count_t hc;
  } exp_t;

  exp_t   sbq[$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint t_start = 0;
  longint t_done = 0;
  int     start_cnt = 0;
  int     done_cnt = 0;
  bit     silent = 1'b0;
  bit     pend = 1'b0;
  int     cd = 0;
  nonce_t pn = '0;

  localparam digest_t TGT5 = {32'h5, 224'h0};
  localparam hdr_t HDR = {19{32'hDEAD_BEEF}};

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin
    sha_if.sha_done   = 1'b0;
    sha_if.sha_digest = '0;
  end

  // SHA core model
  always @(negedge clk) begin
    if (sha_if.sha_done) sha_if.sha_done = 1'b0;
    if (pend) begin
      cd--;
      if (cd == 0) begin
        sha_if.sha_done   = 1'b1;
        sha_if.sha_digest = {pn, {224{1'b1}}};
        pend = 1'b0;
      end
    end
    if (sha_if.sha_start && !silent) begin
      pend = 1'b1;
      cd   = 64;
      pn   = sha_if.sha_msg[NONCE_W-1:0];
    end
  end

  // Monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    exp_t e;
    if (sha_if.sha_start) begin
      start_cnt++;
      t_start = cyc;
    end
    if (done_o) begin
      done_cnt++;
      t_done = cyc;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done with empty queue want none");
      end else begin
        e = sbq.pop_front();
        chk("sb_found", 64'(found_o), 64'(e.found));
        chk("sb_found_nonce", 64'(found_nonce_o), 64'(e.fn));
        chk("sb_timeout_err", 64'(timeout_err_o), 64'(e.terr));
        chk("sb_hash_count", 64'(hash_count_o), 64'(e.hc));
      end
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'd0);
    chk({tag, "_done"}, 64'(done_o), 64'd0);
    chk({tag, "_found"}, 64'(found_o), 64'd0);
    chk({tag, "_fnonce"}, 64'(found_nonce_o), 64'd0);
    chk({tag, "_terr"}, 64'(timeout_err_o), 64'd0);
    chk({tag, "_hcnt"}, 64'(hash_count_o), 64'd0);
    chk({tag, "_sha_start"}, 64'(sha_if.sha_start), 64'd0);
    chk({tag, "_sha_msg_zero"}, 64'(sha_if.sha_msg == '0), 64'd1);
  endtask

  task automatic do_start(digest_t tgt, nonce_t first, nonce_t last);
    @(posedge clk);
    #1;
    hdr_i         = HDR;
    target_i      = tgt;
    nonce_first_i = first;
    nonce_last_i  = last;
    start_i       = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(string tag, int maxc);
    int n = 0;
    while (busy_o && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy_o) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: got busy after %0d cycles want idle", tag, maxc);
    end
    @(negedge clk);
  endtask

  initial begin
    int s0, d0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("post_reset");

    // 1: no winner across 0x10..0x14
    s0 = start_cnt;
    sbq.push_back('{1'b0, 32'h0, 1'b0, 33'd5});
    do_start(TGT5, 32'h10, 32'h14);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_hdr_field", 64'(sha_if.sha_msg[MSG_W-1:NONCE_W] == HDR), 64'd1);
    chk("t1_msg_nonce", 64'(sha_if.sha_msg[NONCE_W-1:0]), 64'h10);
    wait_done("t1", 1000);
    chk("t1_sha_starts", 64'(start_cnt - s0), 64'd5);

    // 2: wrap through 0xFFFFFFFF, nonce 0 wins
    sbq.push_back('{1'b1, 32'h0, 1'b0, 33'd3});
    do_start(TGT5, 32'hFFFF_FFFE, 32'h3);
    wait_done("t2", 1000);

    // 3: digest equal to target is not a win
    sbq.push_back('{1'b0, 32'h0, 1'b0, 33'd1});
    do_start({32'h10, {224{1'b1}}}, 32'h10, 32'h10);
    wait_done("t3", 500);

    // 4: SHA never answers
    silent = 1'b1;
    sbq.push_back('{1'b0, 32'h0, 1'b1, 33'd0});
    do_start(TGT5, 32'h7, 32'h9);
    wait_done("t4", 1300);
    chk("t4_timeout_latency", 64'(t_done - t_start), 64'(TIMEOUT + 2));
    silent = 1'b0;

    // 5: abort mid-WAIT, late sha_done ignored, then fresh sweep
    d0 = done_cnt;
    do_start(TGT5, 32'h40, 32'h50);
    repeat (11) @(posedge clk);
    #1 abort_i = 1'b1;
    @(posedge clk);
    #1 abort_i = 1'b0;
    chk("t5_busy_after_abort", 64'(busy_o), 64'd0);
    repeat (70) @(posedge clk);
    #1;
    chk("t5_busy_after_late_done", 64'(busy_o), 64'd0);
    chk("t5_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t5_hcnt_kept", 64'(hash_count_o), 64'd0);
    hdr_i    = HDR;
    target_i = TGT5;
    start_i  = 1'b1;
    abort_i  = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    chk("t5_abort_beats_start", 64'(busy_o), 64'd0);
    sbq.push_back('{1'b1, 32'h0, 1'b0, 33'd1});
    do_start(TGT5, 32'h0, 32'h0);
    wait_done("t5", 500);

    // 6: start while busy ignored, then reset mid-WAIT
    s0 = start_cnt;
    sbq.push_back('{1'b0, 32'h0, 1'b0, 33'd2});
    do_start(TGT5, 32'h20, 32'h21);
    repeat (5) @(posedge clk);
    #1;
    target_i      = {256{1'b1}};
    nonce_first_i = 32'h0;
    nonce_last_i  = 32'h0;
    start_i       = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("t6_msg_nonce_kept", 64'(sha_if.sha_msg[NONCE_W-1:0]), 64'h20);
    wait_done("t6", 1000);
    chk("t6_sha_starts", 64'(start_cnt - s0), 64'd2);
    repeat (70) @(posedge clk);
    d0 = done_cnt;
    do_start(TGT5, 32'h60, 32'h61);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_zero("t6_in_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("t6_after_rst");
    repeat (70) @(posedge clk);
    #1;
    chk("t6_late_done_idle", 64'(busy_o), 64'd0);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
